// File: rtl/nibble_serial_comparator_pkg.sv
// Shared types and helpers for the nibble-serial magnitude comparator.
package nibble_serial_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot compare result as produced by a slice and held at the outputs.
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_t;

  // Result value that means "no unequal nibble seen yet".
  localparam cmp_t CMP_EQ = '{eq: 1'b1, gt: 1'b0, lt: 1'b0};

  // Widest operand the nibble selector can address.
  localparam int MAX_WIDTH = 256;

  function automatic int nibbles_of(input int width);
    return width / 4;
  endfunction

  // Counter width able to hold 0..NIBBLES.
  function automatic int count_width(input int width);
    return $clog2(width / 4 + 1);
  endfunction

  // Select nibble idx (0 = least significant) from a zero-extended operand.
  function automatic logic [3:0] nibble_sel(input logic [MAX_WIDTH-1:0] v, input int idx);
    return v[idx*4 +: 4];
  endfunction

endpackage

// File: rtl/fourbit_comparator.sv
// Combinational 4-bit magnitude compare slice with cascade inputs.
// The cascade inputs pass through only when the two nibbles are equal.
module fourbit_comparator (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       eq_i,
  input  logic       gt_i,
  input  logic       lt_i,
  output logic       eq_o,
  output logic       gt_o,
  output logic       lt_o
);

  // Local nibble decides; equal nibbles defer to the cascade.
  always_comb begin
    if (a_i > b_i) begin
      {eq_o, gt_o, lt_o} = 3'b010;
    end else if (a_i < b_i) begin
      {eq_o, gt_o, lt_o} = 3'b001;
    end else begin
      {eq_o, gt_o, lt_o} = {eq_i, gt_i, lt_i};
    end
  end

endmodule

// File: rtl/nibble_serial_comparator.sv
// Wide unsigned compare walked MSB nibble first through a single 4-bit slice.
// Captures operands on an accepted start, optionally exits on the first
// unequal nibble, then reports held one-hot eq/gt/lt with a one-cycle done.
module nibble_serial_comparator
  import nibble_serial_comparator_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  bit EARLY_EXIT = 1'b1,
  localparam int NIBBLES    = nibbles_of(WIDTH),
  localparam int CW         = count_width(WIDTH),
  localparam int IW         = $clog2(NIBBLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic [CW-1:0]    cycles
);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  cmp_t             sticky_q, sticky_d;
  cmp_t             res_q, res_d;
  cmp_t             slice;
  cmp_t             sticky_nx;
  logic [3:0]       nib_a, nib_b;
  logic             slice_ne;

  assign nib_a = nibble_sel(MAX_WIDTH'(a_q), int'(idx_q));
  assign nib_b = nibble_sel(MAX_WIDTH'(b_q), int'(idx_q));

  fourbit_comparator u_slice (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .eq_i (CMP_EQ.eq),
    .gt_i (CMP_EQ.gt),
    .lt_i (CMP_EQ.lt),
    .eq_o (slice.eq),
    .gt_o (slice.gt),
    .lt_o (slice.lt)
  );

  assign slice_ne = slice.gt | slice.lt;

  // The first unequal nibble wins; later nibbles never override it.
  assign sticky_nx = (!(sticky_q.gt || sticky_q.lt) && slice_ne) ? slice : sticky_q;

  // Next-state, capture, nibble walk and result load.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    res_d    = res_q;
    cycles_d = cycles_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d      = a;
          b_d      = b;
          idx_d    = IW'(NIBBLES - 1);
          count_d  = '0;
          sticky_d = CMP_EQ;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        count_d  = count_q + CW'(1);
        sticky_d = sticky_nx;
        if ((EARLY_EXIT && slice_ne) || (idx_q == '0)) begin
          res_d    = sticky_nx;
          cycles_d = count_q + CW'(1);
          state_d  = DONE;
        end else begin
          idx_d    = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      count_q  <= '0;
      sticky_q <= CMP_EQ;
      res_q    <= '0;
      cycles_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
      res_q    <= res_d;
      cycles_q <= cycles_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign eq     = res_q.eq;
  assign gt     = res_q.gt;
  assign lt     = res_q.lt;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_nibble_serial_comparator.sv
// Bench for nibble_serial_comparator at WIDTH=16: one early-exit and one
// fixed-latency instance share stimulus; results are checked from a queue.
module tb_nibble_serial_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a, b;

  logic       busy1, done1, eq1, gt1, lt1;
  logic [2:0] cyc1;
  logic       busy0, done0, eq0, gt0, lt0;
  logic [2:0] cyc0;

  always #5 clk = ~clk;

  nibble_serial_comparator #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_ee1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1), .cycles(cyc1)
  );

  nibble_serial_comparator #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_ee0 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .eq(eq0), .gt(gt0), .lt(lt0), .cycles(cyc0)
  );

  typedef struct {
    logic eq;
    logic gt;
    logic lt;
    int   cyc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e1;
    exp_t        e0;
  } vec_t;

  exp_t q1[$];
  exp_t q0[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   dones1   = 0;
  int   dones0   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic exp_t mk(input logic e, input logic g, input logic l, input int c);
    exp_t r;
    r.eq = e; r.gt = g; r.lt = l; r.cyc = c;
    return r;
  endfunction

  function automatic vec_t mkv(input logic [15:0] va, input logic [15:0] vb,
                               input exp_t e1, input exp_t e0);
    vec_t v;
    v.a = va; v.b = vb; v.e1 = e1; v.e0 = e0;
    return v;
  endfunction

  // Reference: plain integer compare; early-exit latency from the first differing nibble.
  function automatic exp_t ref_cmp(input logic [15:0] ra, input logic [15:0] rb, input bit ee);
    exp_t r;
    bit   found = 1'b0;
    r.eq  = (ra == rb);
    r.gt  = (ra > rb);
    r.lt  = (ra < rb);
    r.cyc = 4;
    if (ee && ra != rb) begin
      for (int i = 3; i >= 0; i--) begin
        if (!found && ra[i*4 +: 4] != rb[i*4 +: 4]) begin
          r.cyc = 4 - i;
          found = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, " ee1 outs"}, int'({busy1, done1, eq1, gt1, lt1, cyc1}), 0);
    check({tag, " ee0 outs"}, int'({busy0, done0, eq0, gt0, lt0, cyc0}), 0);
  endtask

  // Scoreboard: every done pops the oldest expected result for that instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (done1) begin
          dones1++;
          if (q1.size() == 0) check("ee1 unexpected done", 1, 0);
          else begin
            e = q1.pop_front();
            check("ee1 flags", int'({eq1, gt1, lt1}), int'({e.eq, e.gt, e.lt}));
            check("ee1 cycles", int'(cyc1), e.cyc);
          end
        end
        if (done0) begin
          dones0++;
          if (q0.size() == 0) check("ee0 unexpected done", 1, 0);
          else begin
            e = q0.pop_front();
            check("ee0 flags", int'({eq0, gt0, lt0}), int'({e.eq, e.gt, e.lt}));
            check("ee0 cycles", int'(cyc0), e.cyc);
          end
        end
      end
    end
  end

  // Waits (bounded) from the first RUN cycle for both dones; -1 means timeout.
  task automatic wait_done(input int budget, output int l1, output int l0);
    l1 = -1;
    l0 = -1;
    for (int t = 1; t <= budget; t++) begin
      @(negedge clk);
      if (t == 1) start = 1'b0;
      if (done1 && l1 < 0) l1 = t;
      if (done0 && l0 < 0) l0 = t;
      if (l1 >= 0 && l0 >= 0) break;
    end
  endtask

  task automatic run_vec(input vec_t v, input bit inject);
    int l1, l0;
    @(negedge clk);
    start = 1'b1;
    a     = v.a;
    b     = v.b;
    q1.push_back(v.e1);
    q0.push_back(v.e0);
    @(negedge clk);
    check("busy after accept", int'({busy1, busy0}), 3);
    if (inject) begin
      start = 1'b1;
      a     = 16'h0000;
      b     = 16'hFFFF;
    end else begin
      start = 1'b0;
      a     = 16'($urandom);
      b     = 16'($urandom);
    end
    wait_done(12, l1, l0);
    check("ee1 latency", l1, v.e1.cyc);
    check("ee0 latency", l0, v.e0.cyc);
  endtask

  initial begin
    vec_t tbl[9];
    vec_t v;
    int   l1, l0, d1, d0, n;

    tbl[0] = mkv(16'h1234, 16'h1234, mk(1, 0, 0, 4), mk(1, 0, 0, 4));
    tbl[1] = mkv(16'h8000, 16'h7FFF, mk(0, 1, 0, 1), mk(0, 1, 0, 4));
    tbl[2] = mkv(16'h00A0, 16'h00A1, mk(0, 0, 1, 4), mk(0, 0, 1, 4));
    tbl[3] = mkv(16'hFFFF, 16'h0000, mk(0, 1, 0, 1), mk(0, 1, 0, 4));
    tbl[4] = mkv(16'h0000, 16'h0001, mk(0, 0, 1, 4), mk(0, 0, 1, 4));
    tbl[5] = mkv(16'h1234, 16'h1334, mk(0, 0, 1, 2), mk(0, 0, 1, 4));
    tbl[6] = mkv(16'h5555, 16'h5550, mk(0, 1, 0, 4), mk(0, 1, 0, 4));
    tbl[7] = mkv(16'hABCD, 16'hAB0D, mk(0, 1, 0, 3), mk(0, 1, 0, 4));
    tbl[8] = mkv(16'h0000, 16'h0000, mk(1, 0, 0, 4), mk(1, 0, 0, 4));

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check_zero("in reset");
    rst = 1'b0;
    @(negedge clk);
    check_zero("after reset");

    // Reset during the second RUN cycle aborts with no done.
    start = 1'b1;
    a     = 16'h1234;
    b     = 16'h1235;
    @(negedge clk);
    start = 1'b0;
    check("abort busy", int'({busy1, busy0}), 3);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_zero("mid-run reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("no done after abort", dones1 + dones0, 0);
    check_zero("idle after abort");

    for (int i = 0; i < 9; i++) run_vec(tbl[i], 1'b0);

    // Start pulsed during RUN is ignored; exactly one done, result held.
    d1 = dones1;
    d0 = dones0;
    run_vec(mkv(16'h0F00, 16'h0E00, mk(0, 1, 0, 2), mk(0, 1, 0, 4)), 1'b1);
    repeat (6) @(negedge clk);
    check("single done ee1", dones1 - d1, 1);
    check("single done ee0", dones0 - d0, 1);
    check("hold ee1", int'({eq1, gt1, lt1, cyc1}), int'({3'b010, 3'd2}));
    check("hold ee0", int'({eq0, gt0, lt0, cyc0}), int'({3'b010, 3'd4}));

    // Back-to-back: new start in the fixed-latency done cycle.
    @(negedge clk);
    start = 1'b1;
    a     = 16'h8000;
    b     = 16'h0000;
    q1.push_back(mk(0, 1, 0, 1));
    q0.push_back(mk(0, 1, 0, 4));
    @(negedge clk);
    a = 16'h1111;
    b = 16'h2222;
    wait_done(12, l1, l0);
    check("b2b first ee1 latency", l1, 1);
    check("b2b first ee0 latency", l0, 4);
    start = 1'b1;
    a     = 16'h0005;
    b     = 16'h0005;
    q1.push_back(mk(1, 0, 0, 4));
    q0.push_back(mk(1, 0, 0, 4));
    @(negedge clk);
    check("b2b no idle gap", int'({busy1, busy0}), 3);
    check("b2b ee0 holds gt", int'({eq0, gt0, lt0}), int'(3'b010));
    wait_done(12, l1, l0);
    check("b2b second ee1 latency", l1, 4);
    check("b2b second ee0 latency", l0, 4);

    // Random operands, often differing in a single nibble.
    for (int i = 0; i < 8; i++) begin
      v.a = 16'($urandom);
      v.b = v.a;
      if ($urandom_range(0, 3) != 0) begin
        n = $urandom_range(0, 3);
        v.b[n*4 +: 4] = v.b[n*4 +: 4] ^ 4'($urandom_range(1, 15));
      end
      v.e1 = ref_cmp(v.a, v.b, 1'b1);
      v.e0 = ref_cmp(v.a, v.b, 1'b0);
      run_vec(v, 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queues drained", q1.size() + q0.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
